// File: rtl/boot_load_sequencer.sv
// boot_load_sequencer: streams program words into shared memory,
// then releases controller and node resets in order.
module boot_load_sequencer #(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 32,
    parameter int MEM_SIZE       = 4096,
    parameter int SETTLE_CYCLES  = 2,
    parameter int NODE_DELAY     = 4
) (
    input  logic                        clk,
    input  logic                        res_n,
    input  logic                        start,
    input  logic                        src_valid,
    input  logic [AXI_DATA_WIDTH-1:0]   src_data,
    output logic                        src_ready,
    output logic                        we_ext,
    output logic [AXI_ADDR_WIDTH-1:0]   dload_addr,
    output logic [AXI_DATA_WIDTH-1:0]   dload_data,
    output logic                        res_n_controller,
    output logic                        res_n_nodes,
    output logic                        busy,
    output logic                        done,
    output logic [$clog2(MEM_SIZE):0]   load_count
);

    localparam int LCW     = $clog2(MEM_SIZE) + 1;
    localparam int DLY_MAX = (SETTLE_CYCLES > NODE_DELAY) ?
                             SETTLE_CYCLES : NODE_DELAY;
    localparam int CW      = $clog2(DLY_MAX) + 1;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SETTLE,
        REL_CTRL,
        RUN
    } state_t;

    state_t        state;
    state_t        next_state;
    logic [CW-1:0] dly;
    logic          accept;
    logic          last_beat;

    assign src_ready = (state == LOAD);
    assign busy      = (state == LOAD) || (state == SETTLE) ||
                       (state == REL_CTRL);
    assign accept    = src_valid & src_ready;
    assign last_beat = accept && (load_count == LCW'(MEM_SIZE - 1));

    // State register
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) state <= IDLE;
        else        state <= next_state;
    end

    // Next-state decode; start is only honoured in IDLE and RUN
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:     if (start)       next_state = LOAD;
            LOAD:     if (last_beat)   next_state = SETTLE;
            SETTLE:   if (dly == '0)   next_state = REL_CTRL;
            REL_CTRL: if (dly == '0)   next_state = RUN;
            RUN:      if (start)       next_state = LOAD;
            default:                   next_state = IDLE;
        endcase
    end

    // Down-counter timing the settle and node-release windows
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            dly <= '0;
        end else if (state == LOAD && next_state == SETTLE) begin
            dly <= CW'(SETTLE_CYCLES - 1);
        end else if (state == SETTLE && next_state == REL_CTRL) begin
            dly <= CW'(NODE_DELAY - 1);
        end else if (dly != '0) begin
            dly <= dly - CW'(1);
        end
    end

    // Word counter; doubles as the preload address of the next beat
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            load_count <= '0;
        end else if (state == IDLE || (state == RUN && start)) begin
            load_count <= '0;
        end else if (accept) begin
            load_count <= load_count + LCW'(1);
        end
    end

    // Preload port: one registered write per accepted beat, else zeros
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            we_ext     <= 1'b0;
            dload_addr <= '0;
            dload_data <= '0;
        end else if (accept) begin
            we_ext     <= 1'b1;
            dload_addr <= AXI_ADDR_WIDTH'(load_count);
            dload_data <= src_data;
        end else begin
            we_ext     <= 1'b0;
            dload_addr <= '0;
            dload_data <= '0;
        end
    end

    // Reset releases and done, registered from the upcoming state
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            res_n_controller <= 1'b0;
            res_n_nodes      <= 1'b0;
            done             <= 1'b0;
        end else begin
            res_n_controller <= (next_state == REL_CTRL) ||
                                (next_state == RUN);
            res_n_nodes      <= (next_state == RUN);
            done             <= (next_state == RUN);
        end
    end

endmodule

// File: tb/tb_boot_load_sequencer.sv
// tb_boot_load_sequencer: directed and randomized boots checked
// against a timestamp-based reference model of the boot sequence.
module tb_boot_load_sequencer;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int MS  = 8;
    localparam int SC  = 2;
    localparam int ND  = 4;
    localparam int LCW = $clog2(MS) + 1;

    logic           clk = 1'b0;
    logic           res_n;
    logic           start;
    logic           src_valid;
    logic [DW-1:0]  src_data;
    logic           src_ready;
    logic           we_ext;
    logic [AW-1:0]  dload_addr;
    logic [DW-1:0]  dload_data;
    logic           res_n_controller;
    logic           res_n_nodes;
    logic           busy;
    logic           done;
    logic [LCW-1:0] load_count;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: load phase, beat count, edge of last beat
    bit          m_load;
    int          m_cnt;
    int          m_tlast;
    int          cyc = 0;
    bit          m_we;
    logic [31:0] m_addr;
    logic [31:0] m_data;

    boot_load_sequencer #(
        .AXI_ADDR_WIDTH (AW),
        .AXI_DATA_WIDTH (DW),
        .MEM_SIZE       (MS),
        .SETTLE_CYCLES  (SC),
        .NODE_DELAY     (ND)
    ) dut (
        .clk              (clk),
        .res_n            (res_n),
        .start            (start),
        .src_valid        (src_valid),
        .src_data         (src_data),
        .src_ready        (src_ready),
        .we_ext           (we_ext),
        .dload_addr       (dload_addr),
        .dload_data       (dload_data),
        .res_n_controller (res_n_controller),
        .res_n_nodes      (res_n_nodes),
        .busy             (busy),
        .done             (done),
        .load_count       (load_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h",
                     tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        m_load  = 1'b0;
        m_cnt   = 0;
        m_tlast = -1;
        m_we    = 1'b0;
        m_addr  = '0;
        m_data  = '0;
    endtask

    // Advance the model by one rising edge using the inputs held there
    task automatic model_edge();
        cyc++;
        if (!res_n) begin
            model_reset();
            return;
        end
        m_we   = 1'b0;
        m_addr = '0;
        m_data = '0;
        if (m_load) begin
            if (src_valid) begin
                m_we   = 1'b1;
                m_addr = 32'(m_cnt);
                m_data = src_data;
                m_cnt++;
                if (m_cnt == MS) begin
                    m_load  = 1'b0;
                    m_tlast = cyc;
                end
            end
        end else if (m_tlast < 0) begin
            m_cnt = 0;
            if (start) m_load = 1'b1;
        end else if ((cyc - 1 >= m_tlast + SC + ND) && start) begin
            m_load  = 1'b1;
            m_cnt   = 0;
            m_tlast = -1;
        end
    endtask

    task automatic compare_all();
        bit post;
        bit e_ctrl;
        bit e_nodes;
        bit e_busy;
        post    = (m_tlast >= 0);
        e_ctrl  = post && (cyc >= m_tlast + SC);
        e_nodes = post && (cyc >= m_tlast + SC + ND);
        e_busy  = m_load || (post && (cyc < m_tlast + SC + ND));
        chk("we_ext",     64'(we_ext),           64'(m_we));
        chk("dload_addr", 64'(dload_addr),       64'(m_addr));
        chk("dload_data", 64'(dload_data),       64'(m_data));
        chk("src_ready",  64'(src_ready),        64'(m_load));
        chk("busy",       64'(busy),             64'(e_busy));
        chk("done",       64'(done),             64'(e_nodes));
        chk("res_ctrl",   64'(res_n_controller), 64'(e_ctrl));
        chk("res_nodes",  64'(res_n_nodes),      64'(e_nodes));
        chk("load_count", 64'(load_count),       64'(m_cnt));
        chk("order_nodes_before_ctrl",
            64'(res_n_nodes & ~res_n_controller), 64'(0));
        chk("order_we_with_ctrl",
            64'(we_ext & res_n_controller), 64'(0));
    endtask

    // Drive inputs, cross one rising edge, check at the falling edge
    task automatic tick(input bit v, input logic [DW-1:0] d,
                        input bit s);
        src_valid = v;
        src_data  = d;
        start     = s;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        res_n     = 1'b0;
        start     = 1'b0;
        src_valid = 1'b0;
        src_data  = '0;
        model_reset();
        #1;
        compare_all();
        tick(1'b0, '0, 1'b0);
        tick(1'b1, 32'h55, 1'b0);
        res_n = 1'b1;

        // Valid in IDLE must not write
        for (int i = 0; i < 3; i++) tick(1'b1, 32'hDEAD0 + 32'(i), 1'b0);
        chk("idle_no_write", 64'(we_ext), 64'(0));

        // Continuous load of 0xA0..0xA7
        tick(1'b0, '0, 1'b1);
        chk("start_ready", 64'(src_ready), 64'(1));
        for (int i = 0; i < MS; i++) tick(1'b1, 32'hA0 + 32'(i), 1'b0);
        chk("last_we",   64'(we_ext),     64'(1));
        chk("last_addr", 64'(dload_addr), 64'(7));
        chk("last_data", 64'(dload_data), 64'(32'hA7));
        tick(1'b0, '0, 1'b0);
        chk("ctrl_at_e1", 64'(res_n_controller), 64'(0));
        chk("we_off_e1",  64'(we_ext),           64'(0));
        tick(1'b0, '0, 1'b0);
        chk("ctrl_at_e2",  64'(res_n_controller), 64'(1));
        chk("nodes_at_e2", 64'(res_n_nodes),      64'(0));
        for (int i = 0; i < ND - 1; i++) tick(1'b0, '0, 1'b0);
        chk("nodes_at_e5", 64'(res_n_nodes), 64'(0));
        tick(1'b0, '0, 1'b0);
        chk("nodes_at_e6", 64'(res_n_nodes), 64'(1));
        chk("done_at_e6",  64'(done),        64'(1));
        tick(1'b0, '0, 1'b0);

        // Reboot from RUN, then stalled source 1,0,0,...
        tick(1'b0, '0, 1'b1);
        chk("reboot_ctrl",  64'(res_n_controller), 64'(0));
        chk("reboot_nodes", 64'(res_n_nodes),      64'(0));
        chk("reboot_done",  64'(done),             64'(0));
        for (int i = 0; i < 3 * MS; i++)
            tick((i % 3) == 0, $urandom, 1'b0);
        chk("stall_count", 64'(load_count), 64'(MS));
        for (int i = 0; i < SC + ND + 2; i++) tick(1'b0, '0, 1'b0);

        // Mid-LOAD start is ignored
        tick(1'b0, '0, 1'b1);
        for (int i = 0; i < 4; i++) tick(1'b1, $urandom, 1'b0);
        tick(1'b1, $urandom, 1'b1);
        tick(1'b1, $urandom, 1'b1);
        chk("mid_start_count", 64'(load_count), 64'(6));
        for (int i = 0; i < 12; i++) tick(1'b1, $urandom, 1'b0);

        // Asynchronous reset after 5 words
        tick(1'b0, '0, 1'b1);
        for (int i = 0; i < 5; i++) tick(1'b1, $urandom, 1'b0);
        #2;
        res_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        chk("abort_count", 64'(load_count), 64'(0));
        tick(1'b1, $urandom, 1'b1);
        res_n = 1'b1;
        tick(1'b0, '0, 1'b1);
        tick(1'b1, 32'hC0, 1'b0);
        chk("restart_addr", 64'(dload_addr), 64'(0));
        chk("restart_data", 64'(dload_data), 64'(32'hC0));

        // Randomized boots with random stalls and start pulses
        for (int i = 0; i < 400; i++)
            tick($urandom_range(0, 3) != 0, $urandom,
                 $urandom_range(0, 11) == 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
